seg_counter_display: RTL and testbench

//  Parametrised N-digit BCD up/down counter with integrated 7-segment scan driver.

---
 rtl/seg_counter_display_if.sv | 25 ++
 rtl/seg_counter_display.sv | 168 ++++++++++++++++
 tb/tb_seg_counter_display.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/seg_counter_display_if.sv
// Control/status bundle for seg_counter_display: count control in, BCD count and
// 7-segment scan outputs back to the controller.
interface seg_counter_display_if #(
   parameter int DIGITS = 6
);
   logic                  run;
   logic                  up;
   logic                  clr;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  carry;
   logic [DIGITS-1:0]     seg_sel;
   logic [7:0]            seg_data;

   modport master (
      output run, up, clr, load, load_val,
      input  bcd_out, carry, seg_sel, seg_data
   );

   modport slave (
      input  run, up, clr, load, load_val,
      output bcd_out, carry, seg_sel, seg_data
   );
endinterface

// File: rtl/seg_counter_display.sv
// N-digit BCD up/down counter with prescaled tick, wrap flag and a multiplexed
// 7-segment scan driver with optional leading-zero blanking.
module seg_counter_display #(
   parameter int DIGITS         = 6,
   parameter int TICK_DIV       = 50_000_000,
   parameter int SCAN_DIV       = 50_000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit SEL_ACTIVE_LOW = 1'b1,
   parameter bit BLANK_LZ       = 1'b1
) (
   input  logic                 clk,
   input  logic                 rstn,
   seg_counter_display_if.slave bus
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

   localparam logic [DIGITS-1:0] SEL_OFF  = SEL_ACTIVE_LOW ? '1 : '0;
   localparam logic [7:0]        DATA_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

   logic [PW-1:0]         presc;
   logic                  tick;
   logic [4*DIGITS-1:0]   count;
   logic [4*DIGITS-1:0]   count_step;
   logic [4*DIGITS-1:0]   load_clamped;
   logic                  wrap;
   logic                  ripple;
   logic                  carry_r;

   logic [SW-1:0]         scan_cnt;
   logic [IW-1:0]         scan_idx;
   logic [DIGITS-1:0]     blank;
   logic                  lead_zero;
   logic [3:0]            cur_digit;
   logic                  cur_blank;
   logic [DIGITS-1:0]     sel_r;
   logic [7:0]            data_r;

   // Active-low segment codes {dp,g,f,e,d,c,b,a}, dp always off.
   function automatic logic [7:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 8'hC0;
         4'd1:    seg_code = 8'hF9;
         4'd2:    seg_code = 8'hA4;
         4'd3:    seg_code = 8'hB0;
         4'd4:    seg_code = 8'h99;
         4'd5:    seg_code = 8'h92;
         4'd6:    seg_code = 8'h82;
         4'd7:    seg_code = 8'hF8;
         4'd8:    seg_code = 8'h80;
         4'd9:    seg_code = 8'h90;
         default: seg_code = 8'hFF;
      endcase
   endfunction

   assign tick = bus.run && (presc == PRESC_MAX);

   // Ripple increment/decrement across all digits in one cycle; wrap is the
   // carry/borrow falling out of the top digit.
   always_comb begin
      count_step = count;
      ripple     = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (ripple) begin
            if (bus.up) begin
               if (count[4*i +: 4] == 4'd9) begin
                  count_step[4*i +: 4] = 4'd0;
               end else begin
                  count_step[4*i +: 4] = count[4*i +: 4] + 4'd1;
                  ripple               = 1'b0;
               end
            end else begin
               if (count[4*i +: 4] == 4'd0) begin
                  count_step[4*i +: 4] = 4'd9;
               end else begin
                  count_step[4*i +: 4] = count[4*i +: 4] - 4'd1;
                  ripple               = 1'b0;
               end
            end
         end
      end
      wrap = ripple;
   end

   always_comb begin
      load_clamped = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         load_clamped[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd9
                                                                : bus.load_val[4*i +: 4];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         presc   <= '0;
         count   <= '0;
         carry_r <= 1'b0;
      end else begin
         carry_r <= 1'b0;
         if (bus.clr) begin
            presc <= '0;
            count <= '0;
         end else begin
            if (bus.run) begin
               presc <= tick ? '0 : presc + 1'b1;
            end
            if (bus.load) begin
               count <= load_clamped;
            end else if (tick) begin
               count   <= count_step;
               carry_r <= wrap;
            end
         end
      end
   end

   // A digit is blanked when it and every digit above it are zero; digit 0 never is.
   always_comb begin
      blank     = '0;
      lead_zero = 1'b1;
      for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
         lead_zero              = lead_zero && (count[4*(DIGITS-1-k) +: 4] == 4'd0);
         blank[DIGITS-1-k]      = BLANK_LZ && lead_zero;
      end
   end

   always_comb begin
      cur_digit = 4'd0;
      cur_blank = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (IW'(i) == scan_idx) begin
            cur_digit = count[4*i +: 4];
            cur_blank = blank[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scan_cnt <= '0;
         scan_idx <= '0;
         sel_r    <= SEL_OFF;
         data_r   <= DATA_OFF;
      end else begin
         if (scan_cnt == SCAN_MAX) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_MAX) ? '0 : scan_idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         sel_r  <= SEL_ACTIVE_LOW ? ~(DIGITS'(1) << scan_idx) : (DIGITS'(1) << scan_idx);
         data_r <= cur_blank ? DATA_OFF
                             : (SEG_ACTIVE_LOW ? seg_code(cur_digit) : ~seg_code(cur_digit));
      end
   end

   assign bus.bcd_out  = count;
   assign bus.carry    = carry_r;
   assign bus.seg_sel  = sel_r;
   assign bus.seg_data = data_r;

endmodule

// File: tb/tb_seg_counter_display.sv
// Directed bench for seg_counter_display: 3 digits, tick every 4 clk, scan every 2 clk.
module tb_seg_counter_display;

   logic clk;
   logic rstn;
   int   checks   = 0;
   int   failures = 0;

   seg_counter_display_if #(.DIGITS(3)) bus ();

   seg_counter_display #(
      .DIGITS(3),
      .TICK_DIV(4),
      .SCAN_DIV(2),
      .SEG_ACTIVE_LOW(1'b1),
      .SEL_ACTIVE_LOW(1'b1),
      .BLANK_LZ(1'b1)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [2:0] exp_sel [6];
      logic [7:0] exp_data[6];
      logic [2:0] prev;
      logic       found;

      exp_sel[0] = 3'b110; exp_data[0] = 8'h92;
      exp_sel[1] = 3'b110; exp_data[1] = 8'h92;
      exp_sel[2] = 3'b101; exp_data[2] = 8'hFF;
      exp_sel[3] = 3'b101; exp_data[3] = 8'hFF;
      exp_sel[4] = 3'b011; exp_data[4] = 8'hFF;
      exp_sel[5] = 3'b011; exp_data[5] = 8'hFF;

      rstn         = 1'b1;
      bus.run      = 1'b0;
      bus.up       = 1'b1;
      bus.clr      = 1'b0;
      bus.load     = 1'b0;
      bus.load_val = '0;
      #1 rstn = 1'b0;
      #2;
      chk("rst_bcd",   bus.bcd_out,  12'h000);
      chk("rst_carry", bus.carry,    1'b0);
      chk("rst_sel",   bus.seg_sel,  3'b111);
      chk("rst_data",  bus.seg_data, 8'hFF);

      // 1: count up 40 ticks
      step(2);
      rstn    = 1'b1;
      bus.run = 1'b1;
      bus.up  = 1'b1;
      step(3);
      chk("t1_pre_tick", bus.bcd_out, 12'h000);
      step(1);
      chk("t1_first",    bus.bcd_out, 12'h001);
      step(156);
      chk("t1_40",       bus.bcd_out, 12'h040);
      chk("t1_carry",    bus.carry,   1'b0);

      // 2: load 999, wrap up
      bus.load     = 1'b1;
      bus.load_val = 12'h999;
      step(1);
      bus.load = 1'b0;
      chk("t2_load",     bus.bcd_out, 12'h999);
      step(2);
      chk("t2_hold",     bus.bcd_out, 12'h999);
      chk("t2_nocarry",  bus.carry,   1'b0);
      step(1);
      chk("t2_wrap",     bus.bcd_out, 12'h000);
      chk("t2_carry",    bus.carry,   1'b1);
      step(1);
      chk("t2_carry_end", bus.carry,  1'b0);
      chk("t2_after",    bus.bcd_out, 12'h000);

      // 3: clear, count down with borrow
      bus.clr = 1'b1;
      bus.up  = 1'b0;
      step(1);
      bus.clr = 1'b0;
      chk("t3_clr",      bus.bcd_out, 12'h000);
      chk("t3_clr_carry", bus.carry,  1'b0);
      step(3);
      chk("t3_pre",      bus.bcd_out, 12'h000);
      step(1);
      chk("t3_borrow",   bus.bcd_out, 12'h999);
      chk("t3_carry",    bus.carry,   1'b1);
      step(1);
      chk("t3_carry_end", bus.carry,  1'b0);
      chk("t3_hold",     bus.bcd_out, 12'h999);
      step(3);
      chk("t3_998",      bus.bcd_out, 12'h998);
      chk("t3_998_carry", bus.carry,  1'b0);

      // 4: load clamp, clr beats load
      bus.load     = 1'b1;
      bus.load_val = 12'h1C3;
      step(1);
      bus.load = 1'b0;
      chk("t4_clamp",    bus.bcd_out, 12'h193);
      bus.clr      = 1'b1;
      bus.load     = 1'b1;
      bus.load_val = 12'h999;
      step(1);
      bus.clr  = 1'b0;
      bus.load = 1'b0;
      chk("t4_clr_wins", bus.bcd_out, 12'h000);

      // 5: scan with count frozen at 005
      bus.run      = 1'b0;
      bus.load     = 1'b1;
      bus.load_val = 12'h005;
      step(1);
      bus.load = 1'b0;
      chk("t5_load",     bus.bcd_out, 12'h005);
      prev  = bus.seg_sel;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(1);
         if (bus.seg_sel == 3'b110 && prev != 3'b110) found = 1'b1;
         else prev = bus.seg_sel;
      end
      chk("t5_sync",     found, 1'b1);
      chk("t5_sel_0",    bus.seg_sel,  exp_sel[0]);
      chk("t5_data_0",   bus.seg_data, exp_data[0]);
      for (int k = 1; k <= 6; k++) begin
         step(1);
         chk($sformatf("t5_sel_%0d", k),  bus.seg_sel,  exp_sel[k % 6]);
         chk($sformatf("t5_data_%0d", k), bus.seg_data, exp_data[k % 6]);
      end
      chk("t5_frozen",   bus.bcd_out, 12'h005);

      // 6: prescaler freezes at phase 1 while run=0
      bus.clr = 1'b1;
      bus.run = 1'b1;
      bus.up  = 1'b1;
      step(1);
      bus.clr = 1'b0;
      step(1);
      bus.run = 1'b0;
      step(21);
      chk("t6_frozen",   bus.bcd_out, 12'h000);
      bus.run = 1'b1;
      step(2);
      chk("t6_phase",    bus.bcd_out, 12'h000);
      step(1);
      chk("t6_resume",   bus.bcd_out, 12'h001);

      // reset mid-tick, between clock edges
      step(2);
      #2 rstn = 1'b0;
      #1;
      chk("t6_rst_bcd",   bus.bcd_out,  12'h000);
      chk("t6_rst_carry", bus.carry,    1'b0);
      chk("t6_rst_sel",   bus.seg_sel,  3'b111);
      chk("t6_rst_data",  bus.seg_data, 8'hFF);
      @(negedge clk);
      rstn = 1'b1;
      step(3);
      chk("t6_post_pre", bus.bcd_out, 12'h000);
      step(1);
      chk("t6_post_1",   bus.bcd_out, 12'h001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
